// File: rtl/mining_pkg.sv
// Shared types and widths for the nonce search datapath.
// Also holds the hash acceptance rule used by the controller.
package mining_pkg;

  localparam int HDR_W   = 96;
  localparam int NONCE_W = 32;
  localparam int TGT_W   = 8;
  localparam int HASH_W  = 24;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    DONE
  } state_e;

  // Both leading hash bytes must be strictly below the target.
  function automatic logic hash_passes(
    input logic [HASH_W-1:0] hash,
    input logic [TGT_W-1:0]  target
  );
    return (hash[HASH_W-1 -: 8] < target) &&
           (hash[HASH_W-9 -: 8] < target);
  endfunction

endpackage

// File: rtl/nonce_iter.sv
// Current-nonce register with load, wrapping increment
// and end-of-range detection.
module nonce_iter
  import mining_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               inc,
  input  logic [NONCE_W-1:0] first,
  input  logic [NONCE_W-1:0] last,
  output logic [NONCE_W-1:0] nonce,
  output logic               is_last
);

  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] last_q, last_d;

  always_comb begin
    nonce_d = nonce_q;
    last_d  = last_q;
    if (load) begin
      nonce_d = first;
      last_d  = last;
    end else if (inc) begin
      nonce_d = nonce_q + NONCE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nonce_q <= '0;
      last_q  <= '0;
    end else begin
      nonce_q <= nonce_d;
      last_q  <= last_d;
    end
  end

  assign nonce   = nonce_q;
  assign is_last = (nonce_q == last_q);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce search sequencer: issues one hash job per nonce and
// stops on the first passing hash, range end or core timeout.
module nonce_search_ctrl
  import mining_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [HDR_W-1:0]   header_in,
  input  logic [NONCE_W-1:0] nonce_first,
  input  logic [NONCE_W-1:0] nonce_last,
  input  logic [TGT_W-1:0]   target,
  output logic               hc_start,
  output logic [HDR_W-1:0]   hc_header,
  output logic [NONCE_W-1:0] hc_nonce,
  input  logic               hc_done,
  input  logic [HASH_W-1:0]  hc_hash,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic               error,
  output logic [NONCE_W-1:0] nonce_found,
  output logic [HASH_W-1:0]  hash_found,
  output logic [NONCE_W-1:0] attempts
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [HDR_W-1:0]   hdr_q, hdr_d;
  logic [TGT_W-1:0]   tgt_q, tgt_d;
  logic [HASH_W-1:0]  hash_q, hash_d;
  logic [HASH_W-1:0]  hfnd_q, hfnd_d;
  logic [NONCE_W-1:0] nfnd_q, nfnd_d;
  logic [NONCE_W-1:0] att_q, att_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               fnd_q, fnd_d;
  logic               exh_q, exh_d;
  logic               err_q, err_d;
  logic               load, inc, is_last;
  logic [NONCE_W-1:0] nonce;

  nonce_iter u_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .inc     (inc),
    .first   (nonce_first),
    .last    (nonce_last),
    .nonce   (nonce),
    .is_last (is_last)
  );

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    tgt_d   = tgt_q;
    hash_d  = hash_q;
    hfnd_d  = hfnd_q;
    nfnd_d  = nfnd_q;
    att_d   = att_q;
    tmo_d   = tmo_q;
    fnd_d   = fnd_q;
    exh_d   = exh_q;
    err_d   = err_q;
    load    = 1'b0;
    inc     = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            load    = 1'b1;
            hdr_d   = header_in;
            tgt_d   = target;
            fnd_d   = 1'b0;
            exh_d   = 1'b0;
            err_d   = 1'b0;
            att_d   = '0;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          // counts the issue cycle so the wait ends TIMEOUT after hc_start
          tmo_d   = TW'(1);
          state_d = WAIT;
        end
        WAIT: begin
          if (hc_done) begin
            hash_d  = hc_hash;
            state_d = CHECK;
            if (att_q != '1) att_d = att_q + NONCE_W'(1);
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        CHECK: begin
          if (hash_passes(hash_q, tgt_q)) begin
            fnd_d   = 1'b1;
            nfnd_d  = nonce;
            hfnd_d  = hash_q;
            state_d = DONE;
          end else if (is_last) begin
            exh_d   = 1'b1;
            state_d = DONE;
          end else begin
            inc     = 1'b1;
            state_d = ISSUE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      tgt_q   <= '0;
      hash_q  <= '0;
      hfnd_q  <= '0;
      nfnd_q  <= '0;
      att_q   <= '0;
      tmo_q   <= '0;
      fnd_q   <= 1'b0;
      exh_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      tgt_q   <= tgt_d;
      hash_q  <= hash_d;
      hfnd_q  <= hfnd_d;
      nfnd_q  <= nfnd_d;
      att_q   <= att_d;
      tmo_q   <= tmo_d;
      fnd_q   <= fnd_d;
      exh_q   <= exh_d;
      err_q   <= err_d;
    end
  end

  assign hc_start    = (state_q == ISSUE) && !abort;
  assign hc_header   = hdr_q;
  assign hc_nonce    = nonce;
  assign busy        = !((state_q == IDLE) || (state_q == DONE));
  assign found       = fnd_q;
  assign exhausted   = exh_q;
  assign error       = err_q;
  assign nonce_found = nfnd_q;
  assign hash_found  = hfnd_q;
  assign attempts    = att_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Scoreboard bench for nonce_search_ctrl: expected jobs and
// results are queued by the stimulus and popped by a monitor.
module tb_nonce_search_ctrl;

  localparam int TMO = 64;

  typedef struct {
    logic [31:0] nonce;
    logic [95:0] hdr;
  } job_t;

  typedef struct {
    logic        f;
    logic        e;
    logic        r;
    logic [31:0] nf;
    logic [23:0] hf;
    logic [31:0] att;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [95:0] header_in = '0;
  logic [31:0] nonce_first = '0;
  logic [31:0] nonce_last = '0;
  logic [7:0]  target = '0;
  logic        hc_done = 1'b0;
  logic [23:0] hc_hash = '0;
  logic        hc_start;
  logic [95:0] hc_header;
  logic [31:0] hc_nonce;
  logic        busy, found, exhausted, error;
  logic [31:0] nonce_found, attempts;
  logic [23:0] hash_found;

  job_t exp_job[$];
  res_t exp_res[$];
  int   n_chk = 0;
  int   n_fail = 0;

  int          core_lat = 1;
  logic        core_en = 1'b1;
  logic        core_ramp = 1'b0;
  logic [23:0] core_const = '0;
  logic [31:0] rn;
  logic        busy_prev = 1'b0;

  localparam logic [95:0] H1 = 96'h397d9f2f40ca9e6c6b1f3324;
  localparam logic [95:0] H2 = 96'h0123456789abcdef00112233;
  localparam logic [95:0] H3 = 96'hdeadbeefcafef00d55aa55aa;

  nonce_search_ctrl #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .header_in   (header_in),
    .nonce_first (nonce_first),
    .nonce_last  (nonce_last),
    .target      (target),
    .hc_start    (hc_start),
    .hc_header   (hc_header),
    .hc_nonce    (hc_nonce),
    .hc_done     (hc_done),
    .hc_hash     (hc_hash),
    .busy        (busy),
    .found       (found),
    .exhausted   (exhausted),
    .error       (error),
    .nonce_found (nonce_found),
    .hash_found  (hash_found),
    .attempts    (attempts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] core_hash(input logic [31:0] n);
    logic [7:0] b0;
    if (core_ramp) begin
      b0 = 8'h50 - {n[3:0], 4'h0};
      return {b0, 8'h05, 8'hAA};
    end
    return core_const;
  endfunction

  task automatic push_job(input logic [31:0] n, input logic [95:0] h);
    job_t j;
    j.nonce = n;
    j.hdr   = h;
    exp_job.push_back(j);
  endtask

  task automatic push_res(input logic f, input logic e, input logic r,
                          input logic [31:0] nf, input logic [23:0] hf,
                          input logic [31:0] att);
    res_t x;
    x.f = f; x.e = e; x.r = r;
    x.nf = nf; x.hf = hf; x.att = att;
    exp_res.push_back(x);
  endtask

  task automatic do_start(input logic [95:0] h, input logic [31:0] f,
                          input logic [31:0] l, input logic [7:0] t);
    @(negedge clk);
    header_in   = h;
    nonce_first = f;
    nonce_last  = l;
    target      = t;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_to_hc_start", hc_start, 1);
  endtask

  task automatic wait_idle(input string name);
    int cnt;
    cnt = 0;
    while (busy && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    n_chk++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s_idle_wait: busy=%0b after %0d cycles, required 0", name, busy, cnt);
    end
    @(negedge clk);
  endtask

  // hash core model
  initial forever begin
    @(negedge clk);
    if (hc_start && core_en) begin
      rn = hc_nonce;
      repeat (core_lat) @(negedge clk);
      hc_hash = core_hash(rn);
      hc_done = 1'b1;
      @(negedge clk);
      hc_done = 1'b0;
    end
  end

  // monitor
  initial forever begin
    job_t j;
    res_t x;
    @(negedge clk);
    if (hc_start === 1'b1) begin
      if (exp_job.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL job_unexpected: got hc_start nonce %0h, required none", hc_nonce);
      end else begin
        j = exp_job.pop_front();
        chk("job_nonce", hc_nonce, j.nonce);
        chk("job_header", hc_header, j.hdr);
      end
    end
    if (busy_prev && !busy) begin
      if (exp_res.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL res_unexpected: got end of run, required none");
      end else begin
        x = exp_res.pop_front();
        chk("res_found", found, x.f);
        chk("res_exhausted", exhausted, x.e);
        chk("res_error", error, x.r);
        chk("res_attempts", attempts, x.att);
        if (x.f) begin
          chk("res_nonce_found", nonce_found, x.nf);
          chk("res_hash_found", hash_found, x.hf);
        end
      end
    end
    busy_prev = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_hc_start", hc_start, 0);
    chk("rst_flags", {found, exhausted, error}, 0);
    chk("rst_attempts", attempts, 0);
    chk("rst_hc_nonce", hc_nonce, 0);
    chk("rst_hc_header", hc_header, 0);
    chk("rst_found_vals", {nonce_found, hash_found}, 0);
    reset = 1'b1;

    // first job passes
    core_const = 24'h001077;
    push_job(32'h0, H1);
    push_res(1, 0, 0, 32'h0, 24'h001077, 1);
    do_start(H1, 32'h0, 32'h3, 8'hFF);
    wait_idle("t1");

    // target 0: nothing passes
    core_const = 24'h000000;
    for (int i = 5; i <= 8; i++) push_job(32'(i), H1);
    push_res(0, 1, 0, 0, 0, 4);
    do_start(H1, 32'h5, 32'h8, 8'h00);
    wait_idle("t2");

    // wrap across all-ones
    core_const = 24'h200000;
    push_job(32'hFFFFFFFE, H2);
    push_job(32'hFFFFFFFF, H2);
    push_job(32'h0, H2);
    push_job(32'h1, H2);
    push_res(0, 1, 0, 0, 0, 4);
    do_start(H2, 32'hFFFFFFFE, 32'h1, 8'h10);
    wait_idle("t3");

    // strict compare: nonce 2 gives byte0 == target, nonce 3 passes
    core_ramp = 1'b1;
    for (int i = 0; i <= 3; i++) push_job(32'(i), H3);
    push_res(1, 0, 0, 32'h3, 24'h2005AA, 4);
    do_start(H3, 32'h0, 32'h9, 8'h30);
    wait_idle("t_ramp");
    core_ramp = 1'b0;

    // single nonce, second byte equals target
    core_const = 24'h103000;
    push_job(32'h7, H3);
    push_res(0, 1, 0, 0, 0, 1);
    do_start(H3, 32'h7, 32'h7, 8'h30);
    wait_idle("t_single");

    // hash core never answers
    core_en = 1'b0;
    push_job(32'h100, H1);
    push_res(0, 0, 1, 0, 0, 0);
    do_start(H1, 32'h100, 32'h200, 8'hFF);
    cnt = 0;
    while (!error && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_cycles", cnt, TMO);
    chk("timeout_busy", busy, 0);
    repeat (5) @(negedge clk);
    core_en = 1'b1;

    // abort in WAIT, late hc_done ignored
    core_lat   = 3;
    core_const = 24'h000000;
    push_job(32'h20, H2);
    push_res(0, 0, 0, 0, 0, 0);
    do_start(H2, 32'h20, 32'h30, 8'hFF);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("abort_found", found, 0);
    chk("abort_attempts", attempts, 0);
    core_lat = 1;
    push_job(32'h40, H2);
    push_res(1, 0, 0, 32'h40, 24'h000000, 1);
    do_start(H2, 32'h40, 32'h40, 8'hFF);
    wait_idle("t_after_abort");

    // async reset mid-WAIT
    core_lat = 10;
    push_job(32'h60, H1);
    push_res(0, 0, 0, 0, 0, 0);
    do_start(H1, 32'h60, 32'h70, 8'hFF);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hc_nonce", hc_nonce, 0);
    chk("arst_hc_header", hc_header, 0);
    chk("arst_outs", {found, exhausted, error, attempts}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("late_done_attempts", attempts, 0);
    chk("late_done_busy", busy, 0);

    // start while busy leaves latched values alone
    core_lat = 1;
    for (int i = 0; i <= 2; i++) push_job(32'(i), H2);
    push_res(0, 1, 0, 0, 0, 3);
    do_start(H2, 32'h0, 32'h2, 8'h00);
    header_in   = H3;
    nonce_first = 32'h99;
    nonce_last  = 32'h99;
    target      = 8'hFF;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("t_busy_start");

    repeat (3) @(negedge clk);
    chk("job_queue_empty", exp_job.size(), 0);
    chk("res_queue_empty", exp_res.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
